// File: rtl/sft_index_decoder_pkg.sv
// Shared constants for the index decoder: FSM encodings and the
// beat-count width helper used to size the frame counter.
package sft_index_decoder_pkg;

  // Frame accumulator state: empty, or a frame in progress.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  // Beat counter width for a vector of the given width.
  function automatic int sft_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/sft_index_to_onehot.sv
// Combinational binary-index to one-hot decode with range detection.
// An out-of-range index decodes to an all-zero vector.
module sft_index_to_onehot #(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [IW-1:0]    index_i,
  output logic [WIDTH-1:0] onehot_o,
  output logic             in_range_o
);

  // Decode each output bit independently; no bit matches an out-of-range index.
  always_comb begin
    onehot_o   = {WIDTH{1'b0}};
    in_range_o = ({1'b0, index_i} < (IW + 1)'(WIDTH));
    for (int i = 0; i < WIDTH; i++) begin
      onehot_o[i] = (index_i == IW'(i));
    end
  end

endmodule

// File: rtl/sft_index_decoder.sv
// Rebuilds a multi-hot vector from a stream of bit indices. Each frame
// ends with s_last; the completed vector, beat count and dup/error
// flags are presented on a registered output with a valid/ready handshake.
module sft_index_decoder
  import sft_index_decoder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(WIDTH),
  parameter int CW    = sft_cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IW-1:0]    s_index,
  input  logic             s_last,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_unencoded,
  output logic [CW-1:0]    m_count,
  output logic             m_dup,
  output logic             m_error,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dup_q, dup_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] out_vec_q, out_vec_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic             out_dup_q, out_dup_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] onehot_s;
  logic             in_range_s;
  logic             accept_s;
  logic [WIDTH-1:0] base_vec_s, frame_vec_s;
  logic [CW-1:0]    base_cnt_s, frame_cnt_s;
  logic             base_dup_s, frame_dup_s;
  logic             base_err_s, frame_err_s;

  sft_index_to_onehot #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_decode (
    .index_i    (s_index),
    .onehot_o   (onehot_s),
    .in_range_o (in_range_s)
  );

  // The input is free whenever the output slot is empty or being drained.
  assign s_ready  = !out_valid_q || m_ready;
  assign accept_s = s_valid && s_ready;

  // Frame contents including the current beat; an idle accumulator counts as empty.
  always_comb begin
    if (state_q == ST_ACCUM) begin
      base_vec_s = acc_q;
      base_cnt_s = cnt_q;
      base_dup_s = dup_q;
      base_err_s = err_q;
    end else begin
      base_vec_s = {WIDTH{1'b0}};
      base_cnt_s = {CW{1'b0}};
      base_dup_s = 1'b0;
      base_err_s = 1'b0;
    end
    frame_vec_s = base_vec_s | onehot_s;
    frame_dup_s = base_dup_s | (|(base_vec_s & onehot_s));
    frame_err_s = base_err_s | ~in_range_s;
    if (base_cnt_s == {CW{1'b1}}) begin
      frame_cnt_s = base_cnt_s;
    end else begin
      frame_cnt_s = base_cnt_s + CW'(1);
    end
  end

  // Next-state for the accumulator FSM and the output register.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dup_d       = dup_q;
    err_d       = err_q;
    out_vec_d   = out_vec_q;
    out_cnt_d   = out_cnt_q;
    out_dup_d   = out_dup_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;

    if (accept_s && s_last) begin
      state_d     = ST_IDLE;
      acc_d       = {WIDTH{1'b0}};
      cnt_d       = {CW{1'b0}};
      dup_d       = 1'b0;
      err_d       = 1'b0;
      out_vec_d   = frame_vec_s;
      out_cnt_d   = frame_cnt_s;
      out_dup_d   = frame_dup_s;
      out_err_d   = frame_err_s;
      out_valid_d = 1'b1;
    end else if (accept_s) begin
      state_d     = ST_ACCUM;
      acc_d       = frame_vec_s;
      cnt_d       = frame_cnt_s;
      dup_d       = frame_dup_s;
      err_d       = frame_err_s;
      out_valid_d = out_valid_q && !m_ready;
    end else if (m_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      dup_q       <= 1'b0;
      err_q       <= 1'b0;
      out_vec_q   <= {WIDTH{1'b0}};
      out_cnt_q   <= {CW{1'b0}};
      out_dup_q   <= 1'b0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dup_q       <= dup_d;
      err_q       <= err_d;
      out_vec_q   <= out_vec_d;
      out_cnt_q   <= out_cnt_d;
      out_dup_q   <= out_dup_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign m_unencoded = out_vec_q;
  assign m_count     = out_cnt_q;
  assign m_dup       = out_dup_q;
  assign m_error     = out_err_q;
  assign m_valid     = out_valid_q;

endmodule

// File: tb/tb_sft_index_decoder.sv
// Bench for sft_index_decoder: a WIDTH=4 and a WIDTH=5 instance share
// handshake inputs; the WIDTH=4 instance sees the low two index bits.
module tb_sft_index_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_last, m_ready;
  logic [2:0] s_idx;
  logic [1:0] a_index;

  logic       a_srdy, a_dup, a_err, a_valid;
  logic [3:0] a_vec;
  logic [2:0] a_cnt;
  logic       b_srdy, b_dup, b_err, b_valid;
  logic [4:0] b_vec;
  logic [3:0] b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign a_index = s_idx[1:0];

  sft_index_decoder #(.WIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_index(a_index), .s_last(s_last), .s_valid(s_valid),
    .s_ready(a_srdy), .m_unencoded(a_vec), .m_count(a_cnt), .m_dup(a_dup),
    .m_error(a_err), .m_valid(a_valid), .m_ready(m_ready)
  );

  sft_index_decoder #(.WIDTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_index(s_idx), .s_last(s_last), .s_valid(s_valid),
    .s_ready(b_srdy), .m_unencoded(b_vec), .m_count(b_cnt), .m_dup(b_dup),
    .m_error(b_err), .m_valid(b_valid), .m_ready(m_ready)
  );

  task automatic beat(input logic v, input logic l, input logic [2:0] idx, input logic rdy);
    s_valid = v; s_last = l; s_idx = idx; m_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_last = 1'b0; s_idx = 3'd0; m_ready = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    s_valid = 1'b0; s_last = 1'b0; s_idx = 3'd0; m_ready = 1'b0;
    rst_n = 1'b1;
    #7 rst_n = 1'b0;
    #2;
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
    checks++; if (a_vec !== 4'b0000) begin failures++; $display("FAIL reset_vec got=%b exp=0000", a_vec); end
    checks++; if (a_cnt !== 3'd0 || a_dup !== 1'b0 || a_err !== 1'b0) begin failures++; $display("FAIL reset_cnt_flags got=%0d/%b/%b exp=0/0/0", a_cnt, a_dup, a_err); end
    checks++; if (b_valid !== 1'b0 || b_vec !== 5'd0 || b_cnt !== 4'd0) begin failures++; $display("FAIL reset_b got=%b/%b/%0d exp=0/0/0", b_valid, b_vec, b_cnt); end
    checks++; if (a_srdy !== 1'b1) begin failures++; $display("FAIL reset_sready got=%b exp=1", a_srdy); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    beat(1'b1, 1'b0, 3'd2, 1'b1);
    beat(1'b1, 1'b0, 3'd0, 1'b1);
    checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", a_valid); end
    beat(1'b1, 1'b1, 3'd3, 1'b1);
    checks++; if (a_valid !== 1'b1 || a_vec !== 4'b1101) begin failures++; $display("FAIL basic_vec got=%b/%b exp=1/1101", a_valid, a_vec); end
    checks++; if (a_cnt !== 3'd3 || a_dup !== 1'b0 || a_err !== 1'b0) begin failures++; $display("FAIL basic_cnt got=%0d/%b/%b exp=3/0/0", a_cnt, a_dup, a_err); end
    beat(1'b0, 1'b0, 3'd0, 1'b1);
    checks++; if (a_valid !== 1'b0 || a_vec !== 4'b1101 || a_cnt !== 3'd3) begin failures++; $display("FAIL basic_drop got=%b/%b/%0d exp=0/1101/3", a_valid, a_vec, a_cnt); end
  endtask

  task automatic test_dup();
    beat(1'b1, 1'b0, 3'd1, 1'b1);
    beat(1'b1, 1'b1, 3'd1, 1'b1);
    checks++; if (a_valid !== 1'b1 || a_vec !== 4'b0010 || a_cnt !== 3'd2 || a_dup !== 1'b1 || a_err !== 1'b0)
      begin failures++; $display("FAIL dup got=%b/%b/%0d/%b/%b exp=1/0010/2/1/0", a_valid, a_vec, a_cnt, a_dup, a_err); end
    beat(1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_error_w5();
    beat(1'b1, 1'b0, 3'd6, 1'b1);
    beat(1'b1, 1'b1, 3'd0, 1'b1);
    checks++; if (b_valid !== 1'b1 || b_vec !== 5'b00001 || b_cnt !== 4'd2 || b_err !== 1'b1 || b_dup !== 1'b0)
      begin failures++; $display("FAIL err_w5 got=%b/%b/%0d/%b/%b exp=1/00001/2/1/0", b_valid, b_vec, b_cnt, b_err, b_dup); end
    checks++; if (a_vec !== 4'b0101 || a_err !== 1'b0) begin failures++; $display("FAIL err_w4_alias got=%b/%b exp=0101/0", a_vec, a_err); end
    beat(1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8; i++) beat(1'b1, 1'b0, 3'd0, 1'b1);
    beat(1'b1, 1'b1, 3'd0, 1'b1);
    checks++; if (a_cnt !== 3'd7 || a_vec !== 4'b0001 || a_dup !== 1'b1) begin failures++; $display("FAIL sat_a got=%0d/%b/%b exp=7/0001/1", a_cnt, a_vec, a_dup); end
    checks++; if (b_cnt !== 4'd9) begin failures++; $display("FAIL sat_b got=%0d exp=9", b_cnt); end
    beat(1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_vec;
    beat(1'b1, 1'b1, 3'd2, 1'b0);
    checks++; if (a_valid !== 1'b1 || a_vec !== 4'b0100 || a_cnt !== 3'd1) begin failures++; $display("FAIL stall_load got=%b/%b/%0d exp=1/0100/1", a_valid, a_vec, a_cnt); end
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_last = 1'b1; s_idx = 3'd3; m_ready = 1'b0;
      #1;
      checks++; if (a_srdy !== 1'b0) begin failures++; $display("FAIL stall_sready cyc=%0d got=%b exp=0", i, a_srdy); end
      @(posedge clk); #1;
      checks++; if (a_valid !== 1'b1 || a_vec !== 4'b0100 || a_cnt !== 3'd1) begin failures++; $display("FAIL stall_hold cyc=%0d got=%b/%b/%0d exp=1/0100/1", i, a_valid, a_vec, a_cnt); end
    end
    beat(1'b1, 1'b1, 3'd3, 1'b1);
    checks++; if (a_valid !== 1'b1 || a_vec !== 4'b1000) begin failures++; $display("FAIL stall_release got=%b/%b exp=1/1000", a_valid, a_vec); end
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, 1'b1, 3'(i), 1'b1);
      exp_vec = 4'b0001 << i;
      checks++; if (a_valid !== 1'b1 || a_vec !== exp_vec || a_cnt !== 3'd1) begin failures++; $display("FAIL b2b idx=%0d got=%b/%b/%0d exp=1/%b/1", i, a_valid, a_vec, a_cnt, exp_vec); end
    end
    beat(1'b0, 1'b0, 3'd0, 1'b1);
    checks++; if (a_valid !== 1'b0 || a_vec !== 4'b0100) begin failures++; $display("FAIL b2b_end got=%b/%b exp=0/0100", a_valid, a_vec); end
  endtask

  task automatic test_reset_midframe();
    beat(1'b1, 1'b0, 3'd0, 1'b1);
    beat(1'b1, 1'b0, 3'd1, 1'b1);
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_valid !== 1'b0 || a_vec !== 4'b0000) begin failures++; $display("FAIL midrst_async got=%b/%b exp=0/0000", a_valid, a_vec); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    beat(1'b1, 1'b1, 3'd3, 1'b1);
    checks++; if (a_valid !== 1'b1 || a_vec !== 4'b1000 || a_cnt !== 3'd1 || a_dup !== 1'b0) begin failures++; $display("FAIL midrst_frame got=%b/%b/%0d/%b exp=1/1000/1/0", a_valid, a_vec, a_cnt, a_dup); end
    beat(1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_random();
    logic [7:0] fv[2];
    int         fc[2];
    bit         fd[2], fe[2];
    logic [7:0] ovec[2];
    int         ocnt[2];
    bit         odup[2], oerr[2];
    bit         ov, exp_srdy, acc, v, l, r;
    logic [2:0] idx;
    int         ik, w, maxc;
    do_reset();
    ov = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fv[k] = 8'd0; fc[k] = 0; fd[k] = 1'b0; fe[k] = 1'b0;
      ovec[k] = 8'd0; ocnt[k] = 0; odup[k] = 1'b0; oerr[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      v   = ($urandom % 4) != 0;
      l   = ($urandom % 6) == 0;
      r   = ($urandom % 3) != 0;
      idx = 3'($urandom % 8);
      s_valid = v; s_last = l; s_idx = idx; m_ready = r;
      #1;
      exp_srdy = !ov || r;
      checks++; if (a_srdy !== exp_srdy || b_srdy !== exp_srdy) begin failures++; $display("FAIL rnd_sready cyc=%0d got=%b/%b exp=%b", cyc, a_srdy, b_srdy, exp_srdy); end
      acc = v && exp_srdy;
      @(posedge clk);
      if (acc) begin
        for (int k = 0; k < 2; k++) begin
          ik   = (k == 0) ? int'(idx[1:0]) : int'(idx);
          w    = (k == 0) ? 4 : 5;
          maxc = (k == 0) ? 7 : 15;
          if (ik < w) begin
            if (fv[k][ik]) fd[k] = 1'b1;
            else fv[k][ik] = 1'b1;
          end else begin
            fe[k] = 1'b1;
          end
          if (fc[k] < maxc) fc[k] = fc[k] + 1;
          if (l) begin
            ovec[k] = fv[k]; ocnt[k] = fc[k]; odup[k] = fd[k]; oerr[k] = fe[k];
            fv[k] = 8'd0; fc[k] = 0; fd[k] = 1'b0; fe[k] = 1'b0;
          end
        end
      end
      if (acc && l) ov = 1'b1;
      else if (r) ov = 1'b0;
      #1;
      checks++; if (a_valid !== ov || b_valid !== ov) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b/%b exp=%b", cyc, a_valid, b_valid, ov); end
      checks++; if (a_vec !== ovec[0][3:0] || a_cnt !== 3'(ocnt[0]) || a_dup !== odup[0] || a_err !== oerr[0])
        begin failures++; $display("FAIL rnd_a cyc=%0d got=%b/%0d/%b/%b exp=%b/%0d/%b/%b", cyc, a_vec, a_cnt, a_dup, a_err, ovec[0][3:0], ocnt[0], odup[0], oerr[0]); end
      checks++; if (b_vec !== ovec[1][4:0] || b_cnt !== 4'(ocnt[1]) || b_dup !== odup[1] || b_err !== oerr[1])
        begin failures++; $display("FAIL rnd_b cyc=%0d got=%b/%0d/%b/%b exp=%b/%0d/%b/%b", cyc, b_vec, b_cnt, b_dup, b_err, ovec[1][4:0], ocnt[1], odup[1], oerr[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_dup();
    test_error_w5();
    test_saturate();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
